// File: rtl/load_align_unit_if.sv
// Handshake bundle for load_align_unit: load request, cache read port and writeback result.
// The slave modport is the unit itself; the master modport is its environment.
interface load_align_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             ld_valid;
  logic             ld_ready;
  logic [XLEN-1:0]  ld_addr;
  logic [2:0]       ld_type;
  logic [TAG_W-1:0] ld_tag;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [XLEN-1:0]  mem_req_addr;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_data;

  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_fault;

  modport slave (
    input  ld_valid, ld_addr, ld_type, ld_tag,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  wb_ready,
    output ld_ready, mem_req_valid, mem_req_addr,
    output wb_valid, wb_data, wb_tag, wb_fault
  );

  modport master (
    output ld_valid, ld_addr, ld_type, ld_tag,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output wb_ready,
    input  ld_ready, mem_req_valid, mem_req_addr,
    input  wb_valid, wb_data, wb_tag, wb_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load aligner: issues one or two aligned cache reads, merges, shifts and extends.
// LOAD_MISALIGN_SPLIT_EN: when defined, word-crossing loads are split; otherwise they fault.
module load_align_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  load_align_unit_if.slave bus
);
  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  // Load type codes (funct3 layout, NOREGWRITE on the spare code).
  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LW  = 3'd2;
  localparam logic [2:0] LT_LD  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;
  localparam logic [2:0] LT_LWU = 3'd6;

`ifdef LOAD_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

  typedef struct packed {
    logic       legal;
    logic       sgn;
    logic [3:0] size;
  } ld_info_t;

  localparam logic IS64 = (XLEN == 64) ? 1'b1 : 1'b0;

  function automatic ld_info_t decode(input logic [2:0] t);
    ld_info_t i;
    i = '0;
    case (t)
      LT_LB:   i = '{1'b1, 1'b1, 4'd1};
      LT_LH:   i = '{1'b1, 1'b1, 4'd2};
      LT_LW:   i = '{1'b1, 1'b1, 4'd4};
      LT_LBU:  i = '{1'b1, 1'b0, 4'd1};
      LT_LHU:  i = '{1'b1, 1'b0, 4'd2};
      LT_LWU:  i = '{IS64, 1'b0, 4'd4};
      LT_LD:   i = '{IS64, 1'b0, 4'd8};
      default: i = '0;
    endcase
    return i;
  endfunction

  state_t           state;
  logic [OFF_W-1:0] off_q;
  logic [3:0]       size_q;
  logic             sgn_q;
  logic [TAG_W-1:0] tag_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
  logic             cross_q;
  logic [XLEN-1:0]  beat0;
`endif

  ld_info_t         req_info;
  logic [OFF_W-1:0] req_off;
  logic             req_cross;
  logic [XLEN-1:0]  req_aligned;

  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   mask;
  logic              sbit;
  logic [XLEN-1:0]   result;

  assign bus.ld_ready = (state == IDLE) || (state == RESP && bus.wb_ready);

  always_comb begin
    req_info    = decode(bus.ld_type);
    req_off     = bus.ld_addr[OFF_W-1:0];
    req_cross   = req_info.legal && ((5'(req_off) + 5'(req_info.size)) > 5'(BYTES));
    req_aligned = {bus.ld_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  end

  // The final beat is consumed straight off the response bus; only beat0 needs a register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mask = '1;
    sbit = 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
    merged = (state == WAIT1) ? {bus.mem_rsp_data, beat0} : {{XLEN{1'b0}}, bus.mem_rsp_data};
`else
    merged = {{XLEN{1'b0}}, bus.mem_rsp_data};
`endif
    shifted = XLEN'(merged >> {off_q, 3'b000});
    case (size_q)
      4'd1:    begin mask = XLEN'(8'hFF);         sbit = shifted[7];  end
      4'd2:    begin mask = XLEN'(16'hFFFF);      sbit = shifted[15]; end
      4'd4:    begin mask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: begin mask = '1;                   sbit = 1'b0;        end
    endcase
    result = (shifted & mask) | ((sgn_q && sbit) ? ~mask : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state             <= IDLE;
      off_q             <= '0;
      size_q            <= '0;
      sgn_q             <= 1'b0;
      tag_q             <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      cross_q           <= 1'b0;
      beat0             <= '0;
`endif
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.wb_valid      <= 1'b0;
      bus.wb_data       <= '0;
      bus.wb_tag        <= '0;
      bus.wb_fault      <= 1'b0;
    end else begin
      case (state)
        REQ0: if (bus.mem_req_ready) begin
          bus.mem_req_valid <= 1'b0;
          state             <= WAIT0;
        end
        WAIT0: if (bus.mem_rsp_valid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
          if (cross_q) begin
            beat0             <= bus.mem_rsp_data;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= bus.mem_req_addr + XLEN'(BYTES);
            state             <= REQ1;
          end else begin
            bus.wb_valid <= 1'b1;
            bus.wb_data  <= result;
            bus.wb_tag   <= tag_q;
            state        <= RESP;
          end
`else
          bus.wb_valid <= 1'b1;
          bus.wb_data  <= result;
          bus.wb_tag   <= tag_q;
          state        <= RESP;
`endif
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        REQ1: if (bus.mem_req_ready) begin
          bus.mem_req_valid <= 1'b0;
          state             <= WAIT1;
        end
        WAIT1: if (bus.mem_rsp_valid) begin
          bus.wb_valid <= 1'b1;
          bus.wb_data  <= result;
          bus.wb_tag   <= tag_q;
          state        <= RESP;
        end
`endif
        RESP: if (bus.wb_ready) begin
          bus.wb_valid <= 1'b0;
          state        <= IDLE;
        end
        default: ;
      endcase

      // Acceptance overrides the RESP exit so back-to-back loads need no bubble.
      if (bus.ld_valid && bus.ld_ready) begin
        off_q        <= req_off;
        size_q       <= req_info.size;
        sgn_q        <= req_info.sgn;
        tag_q        <= bus.ld_tag;
        bus.wb_data  <= '0;
        bus.wb_fault <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
        cross_q      <= req_cross;
`endif
        if (!req_info.legal) begin
          bus.wb_valid <= 1'b1;
          bus.wb_tag   <= bus.ld_tag;
          state        <= RESP;
        end
`ifndef LOAD_MISALIGN_SPLIT_EN
        else if (req_cross) begin
          bus.wb_valid <= 1'b1;
          bus.wb_tag   <= bus.ld_tag;
          bus.wb_fault <= 1'b1;
          state        <= RESP;
        end
`endif
        else begin
          bus.wb_valid      <= 1'b0;
          bus.mem_req_valid <= 1'b1;
          bus.mem_req_addr  <= req_aligned;
          state             <= REQ0;
        end
      end
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: XLEN=32 and XLEN=64 instances, table vectors
// plus hand-written backpressure and mid-operation reset sequences.
module tb_load_align_unit;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LD = 3'd3;
  localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, LWU = 3'd6, NOREG = 3'd7;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  load_align_unit_if #(.XLEN(32), .TAG_W(5)) b32 ();
  load_align_unit_if #(.XLEN(64), .TAG_W(5)) b64 ();

  load_align_unit #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  load_align_unit #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Selected-DUT views.
  bit sel64 = 1'b0;
  wire        ld_ready_m  = sel64 ? b64.ld_ready : b32.ld_ready;
  wire        req_valid_m = sel64 ? b64.mem_req_valid : b32.mem_req_valid;
  wire [63:0] req_addr_m  = sel64 ? b64.mem_req_addr : {32'h0, b32.mem_req_addr};
  wire        wb_valid_m  = sel64 ? b64.wb_valid : b32.wb_valid;
  wire [63:0] wb_data_m   = sel64 ? b64.wb_data : {32'h0, b32.wb_data};
  wire [4:0]  wb_tag_m    = sel64 ? b64.wb_tag : b32.wb_tag;
  wire        wb_fault_m  = sel64 ? b64.wb_fault : b32.wb_fault;

  // Byte-addressed little-endian backing store.
  logic [7:0] mem [logic [63:0]];

  task automatic put_word(input logic [63:0] a, input logic [63:0] d, input int nb);
    for (int i = 0; i < nb; i++) mem[a + 64'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [63:0] rd_word(input logic [63:0] a, input bit w);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < (w ? 8 : 4); i++)
      if (mem.exists(a + 64'(i))) d[8*i +: 8] = mem[a + 64'(i)];
    return d;
  endfunction

  // Cache responder: one response the cycle after each accepted request.
  bit          auto_rsp  = 1'b1;
  bit          force_rsp = 1'b0;
  bit          pend      = 1'b0;
  logic [63:0] paddr     = '0;
  logic [63:0] req_log [64];
  int          req_cyc [64];
  int          req_n   = 0;
  int          rsp_cyc = 0;

  always @(negedge clk) begin
    logic [63:0] rdata;
    b32.mem_rsp_valid = 1'b0;
    b64.mem_rsp_valid = 1'b0;
    if (pend || force_rsp) begin
      rdata = rd_word(paddr, sel64);
      if (sel64) begin b64.mem_rsp_valid = 1'b1; b64.mem_rsp_data = rdata; end
      else       begin b32.mem_rsp_valid = 1'b1; b32.mem_rsp_data = rdata[31:0]; end
      pend    = 1'b0;
      rsp_cyc = cyc;
    end
    if (auto_rsp && req_valid_m && req_n < 64) begin
      pend           = 1'b1;
      paddr          = req_addr_m;
      req_log[req_n] = req_addr_m;
      req_cyc[req_n] = cyc;
      req_n          = req_n + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ld(input bit v, input logic [63:0] a, input logic [2:0] t, input logic [4:0] g);
    b32.ld_valid = v & ~sel64;
    b64.ld_valid = v & sel64;
    b32.ld_addr  = a[31:0];
    b64.ld_addr  = a;
    b32.ld_type  = t;
    b64.ld_type  = t;
    b32.ld_tag   = g;
    b64.ld_tag   = g;
  endtask

  task automatic set_wb_ready(input bit r);
    b32.wb_ready = r;
    b64.wb_ready = r;
  endtask

  // Waits (bounded) for wb_valid, sampling 1 time unit after each falling edge.
  task automatic wait_wb(output bit seen, output int wb_c);
    seen = 1'b0;
    wb_c = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wb_valid_m) begin seen = 1'b1; wb_c = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_load(input logic [63:0] a, input logic [2:0] t, input logic [4:0] g,
                          output logic [63:0] d, output logic f, output logic [4:0] tg,
                          output bit acc_ok, output bit wb_ok, output int acc_c, output int wb_c);
    @(negedge clk);
    drive_ld(1'b1, a, t, g);
    acc_ok = 1'b0;
    acc_c  = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ld_ready_m) begin acc_ok = 1'b1; acc_c = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    drive_ld(1'b0, a, t, g);
    wait_wb(wb_ok, wb_c);
    d  = wb_data_m;
    f  = wb_fault_m;
    tg = wb_tag_m;
    set_wb_ready(1'b1);
    @(negedge clk);
    set_wb_ready(1'b0);
  endtask

  typedef struct {
    bit          w64;
    logic [63:0] addr;
    logic [2:0]  typ;
    logic [63:0] data;
    bit          fault;
    int          nreq;
    logic [63:0] r0;
    logic [63:0] r1;
  } vec_t;

  function automatic vec_t mk(input bit w, input logic [63:0] a, input logic [2:0] t,
                              input logic [63:0] d, input bit f, input int n,
                              input logic [63:0] r0, input logic [63:0] r1);
    vec_t v;
    v = '{w, a, t, d, f, n, r0, r1};
    return v;
  endfunction

  vec_t vecs [17];

  initial begin
    logic [63:0] d;
    logic        f;
    logic [4:0]  tg;
    bit          acc_ok, wb_ok, any_wb;
    int          acc_c, wb_c, r_start, nr;

    rst_n = 1'b0;
    drive_ld(1'b0, '0, LB, '0);
    set_wb_ready(1'b0);
    b32.mem_req_ready = 1'b1;
    b64.mem_req_ready = 1'b1;
    b32.mem_rsp_data  = '0;
    b64.mem_rsp_data  = '0;

    put_word(64'h1000, 64'h80FF1234, 4);
    put_word(64'h3000, 64'h44332211, 4);
    put_word(64'h3004, 64'h88776655, 4);
    put_word(64'hFFFF_FFFC, 64'hAB000000, 4);
    put_word(64'h0, 64'h000000CD, 4);
    put_word(64'h2000, 64'h8000_0001_0000_0000, 8);
    put_word(64'h2008, 64'h1122_3344_5566_7788, 8);

    vecs[0]  = mk(1'b0, 64'h1003, LB,  64'hFFFF_FF80, 1'b0, 1, 64'h1000, 64'h0);
    vecs[1]  = mk(1'b0, 64'h1001, LHU, 64'h0000_FF12, 1'b0, 1, 64'h1000, 64'h0);
    vecs[2]  = mk(1'b0, 64'h1002, LH,  64'hFFFF_80FF, 1'b0, 1, 64'h1000, 64'h0);
    vecs[3]  = mk(1'b0, 64'h1000, LW,  64'h80FF_1234, 1'b0, 1, 64'h1000, 64'h0);
    vecs[4]  = mk(1'b0, 64'h1003, LBU, 64'h0000_0080, 1'b0, 1, 64'h1000, 64'h0);
`ifdef LOAD_MISALIGN_SPLIT_EN
    vecs[5]  = mk(1'b0, 64'h3001, LW,  64'h5544_3322, 1'b0, 2, 64'h3000, 64'h3004);
    vecs[6]  = mk(1'b0, 64'h3003, LH,  64'h0000_5544, 1'b0, 2, 64'h3000, 64'h3004);
    vecs[7]  = mk(1'b0, 64'hFFFF_FFFF, LH, 64'hFFFF_CDAB, 1'b0, 2, 64'hFFFF_FFFC, 64'h0);
    vecs[15] = mk(1'b1, 64'h2006, LD,  64'h3344_5566_7788_8000, 1'b0, 2, 64'h2000, 64'h2008);
`else
    vecs[5]  = mk(1'b0, 64'h3001, LW,  64'h0, 1'b1, 0, 64'h0, 64'h0);
    vecs[6]  = mk(1'b0, 64'h3003, LH,  64'h0, 1'b1, 0, 64'h0, 64'h0);
    vecs[7]  = mk(1'b0, 64'hFFFF_FFFF, LH, 64'h0, 1'b1, 0, 64'h0, 64'h0);
    vecs[15] = mk(1'b1, 64'h2006, LD,  64'h0, 1'b1, 0, 64'h0, 64'h0);
`endif
    vecs[8]  = mk(1'b0, 64'h1000, LD,    64'h0, 1'b0, 0, 64'h0, 64'h0);
    vecs[9]  = mk(1'b0, 64'h1000, NOREG, 64'h0, 1'b0, 0, 64'h0, 64'h0);
    vecs[10] = mk(1'b0, 64'h1000, LWU,   64'h0, 1'b0, 0, 64'h0, 64'h0);
    vecs[11] = mk(1'b1, 64'h2004, LWU, 64'h0000_0000_8000_0001, 1'b0, 1, 64'h2000, 64'h0);
    vecs[12] = mk(1'b1, 64'h2004, LW,  64'hFFFF_FFFF_8000_0001, 1'b0, 1, 64'h2000, 64'h0);
    vecs[13] = mk(1'b1, 64'h2007, LB,  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 64'h2000, 64'h0);
    vecs[14] = mk(1'b1, 64'h2000, LD,  64'h8000_0001_0000_0000, 1'b0, 1, 64'h2000, 64'h0);
    vecs[16] = mk(1'b1, 64'h2003, LHU, 64'h0000_0000_0000_0100, 1'b0, 1, 64'h2000, 64'h0);

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    #1;
    check("rst32_wb_valid", 64'(b32.wb_valid), 64'h0);
    check("rst32_req_valid", 64'(b32.mem_req_valid), 64'h0);
    check("rst32_wb_fault", 64'(b32.wb_fault), 64'h0);
    check("rst32_wb_data", 64'(b32.wb_data), 64'h0);
    check("rst32_wb_tag", 64'(b32.wb_tag), 64'h0);
    check("rst32_req_addr", 64'(b32.mem_req_addr), 64'h0);
    check("rst32_ld_ready", 64'(b32.ld_ready), 64'h1);
    check("rst64_wb_valid", 64'(b64.wb_valid), 64'h0);
    check("rst64_req_valid", 64'(b64.mem_req_valid), 64'h0);
    check("rst64_wb_data", b64.wb_data, 64'h0);
    check("rst64_req_addr", b64.mem_req_addr, 64'h0);
    check("rst64_ld_ready", 64'(b64.ld_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      sel64   = vecs[i].w64;
      r_start = req_n;
      run_load(vecs[i].addr, vecs[i].typ, 5'(i), d, f, tg, acc_ok, wb_ok, acc_c, wb_c);
      nr = req_n - r_start;
      check($sformatf("v%0d_accepted", i), 64'(acc_ok), 64'h1);
      check($sformatf("v%0d_wb_seen", i), 64'(wb_ok), 64'h1);
      check($sformatf("v%0d_data", i), d, vecs[i].data);
      check($sformatf("v%0d_fault", i), 64'(f), 64'(vecs[i].fault));
      check($sformatf("v%0d_tag", i), 64'(tg), 64'(i));
      check($sformatf("v%0d_nreq", i), 64'(nr), 64'(vecs[i].nreq));
      if (vecs[i].nreq >= 1 && nr >= 1) begin
        check($sformatf("v%0d_req0_addr", i), req_log[r_start], vecs[i].r0);
        check($sformatf("v%0d_req0_cycle", i), 64'(req_cyc[r_start]), 64'(acc_c + 1));
        check($sformatf("v%0d_wb_latency", i), 64'(wb_c), 64'(rsp_cyc + 1));
      end
      if (vecs[i].nreq == 2 && nr == 2)
        check($sformatf("v%0d_req1_addr", i), req_log[r_start + 1], vecs[i].r1);
      if (vecs[i].nreq == 0)
        check($sformatf("v%0d_noacc_latency", i), 64'(wb_c), 64'(acc_c + 1));
    end

    // Backpressure: result held for 3 cycles, then back-to-back accept on the handshake.
    sel64 = 1'b0;
    @(negedge clk);
    drive_ld(1'b1, 64'h1003, LB, 5'd9);
    @(negedge clk);
    drive_ld(1'b0, 64'h1003, LB, 5'd9);
    wait_wb(wb_ok, wb_c);
    check("bp_wb_seen", 64'(wb_ok), 64'h1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold%0d_valid", k), 64'(wb_valid_m), 64'h1);
      check($sformatf("bp_hold%0d_data", k), wb_data_m, 64'hFFFF_FF80);
      check($sformatf("bp_hold%0d_tag", k), 64'(wb_tag_m), 64'd9);
      @(negedge clk);
      #1;
    end
    set_wb_ready(1'b1);
    drive_ld(1'b1, 64'h1001, LHU, 5'd10);
    #1;
    check("bp_ld_ready_in_resp", 64'(ld_ready_m), 64'h1);
    @(negedge clk);
    set_wb_ready(1'b0);
    drive_ld(1'b0, 64'h1001, LHU, 5'd10);
    #1;
    check("bp_next_req_valid", 64'(req_valid_m), 64'h1);
    check("bp_wb_dropped", 64'(wb_valid_m), 64'h0);
    @(negedge clk);
    wait_wb(wb_ok, wb_c);
    check("bp_next_wb_seen", 64'(wb_ok), 64'h1);
    check("bp_next_data", wb_data_m, 64'h0000_FF12);
    check("bp_next_tag", 64'(wb_tag_m), 64'd10);
    set_wb_ready(1'b1);
    @(negedge clk);
    set_wb_ready(1'b0);

    // Reset asserted while waiting for the first beat.
    auto_rsp = 1'b0;
    @(negedge clk);
    drive_ld(1'b1, 64'h1000, LW, 5'd3);
    @(negedge clk);
    drive_ld(1'b0, 64'h1000, LW, 5'd3);
    @(negedge clk);
    #1;
    check("rw_in_wait0_ready", 64'(ld_ready_m), 64'h0);
    check("rw_in_wait0_addr", req_addr_m, 64'h1000);
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_async_ld_ready", 64'(ld_ready_m), 64'h1);
    check("rw_async_req_valid", 64'(req_valid_m), 64'h0);
    check("rw_async_req_addr", req_addr_m, 64'h0);
    check("rw_async_wb_tag", 64'(wb_tag_m), 64'h0);
    check("rw_async_wb_data", wb_data_m, 64'h0);
    check("rw_async_wb_valid", 64'(wb_valid_m), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 force_rsp = 1'b1;
    @(negedge clk);
    #1 force_rsp = 1'b0;
    any_wb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (wb_valid_m || req_valid_m) any_wb = 1'b1;
    end
    check("rw_late_rsp_ignored", 64'(any_wb), 64'h0);
    auto_rsp = 1'b1;
    run_load(64'h1000, LW, 5'd4, d, f, tg, acc_ok, wb_ok, acc_c, wb_c);
    check("rw_after_wb_seen", 64'(wb_ok), 64'h1);
    check("rw_after_data", d, 64'h80FF_1234);
    check("rw_after_tag", 64'(tg), 64'd4);
    check("rw_after_fault", 64'(f), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Sequential successor to the combinational load data extender. It sits between the MEM stage and the data cache read port.
- Accepts one load at a time and issues one or two naturally aligned word reads to the cache.
- Merges the returned beats and shifts out the addressed bytes. Sign- or zero-extends the result to XLEN and returns it with its destination register tag.
- Parametrised in datapath width. Handles loads that cross a word boundary.

Parameters:
- XLEN, 32, datapath and cache word width in bits; legal values 32 or 64.
- TAG_W, 5, width of the destination-register tag carried through the unit.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ld_valid  input  1  load request valid.
- ld_ready  output  1  unit can accept a load this cycle.
- ld_addr  input  XLEN  byte address of the load.
- ld_type  input  3  load type code: NOREGWRITE, LB, LH, LW, LBU, LHU, plus LWU and LD (the last two are legal only when XLEN=64).
- ld_tag  input  TAG_W  destination register tag.
- mem_req_valid  output  1  cache read request valid.
- mem_req_ready  input  1  cache accepts the request.
- mem_req_addr  output  XLEN  word-aligned read address; low log2(XLEN/8) bits are zero.
- mem_rsp_valid  input  1  single-cycle pulse: read data returned.
- mem_rsp_data  input  XLEN  read data.
- wb_valid  output  1  result valid.
- wb_ready  input  1  writeback stage accepts the result.
- wb_data  output  XLEN  aligned and extended load result.
- wb_tag  output  TAG_W  tag of the completed load.
- wb_fault  output  1  misaligned-access fault; wb_data is 0 when set.

Behaviour:
- Reset values, applied immediately on rst_n low regardless of clock: state=IDLE; mem_req_valid, wb_valid and wb_fault = 0; wb_data, wb_tag and mem_req_addr = 0.
- Size by type: B=1 byte, H=2, W=4, D=8.
- off = ld_addr mod (XLEN/8).
- A load "crosses" when off+size > XLEN/8. Unaligned loads that stay within one word are served in one beat with no fault.
- Illegal types (LD/LWU at XLEN=32, unused codes) and NOREGWRITE: no memory access; the result is returned with wb_data=0 and wb_fault=0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: on ld_valid&&ld_ready, latch addr, type, tag and off. Go to REQ0, or straight to RESP when no access is needed.
  - REQ0: mem_req_valid=1, mem_req_addr = word-aligned ld_addr. Hold until mem_req_ready, then go to WAIT0.
  - WAIT0: on mem_rsp_valid, store beat0. If crossing, go to REQ1; otherwise go to RESP.
  - REQ1: mem_req_addr = aligned address + XLEN/8, with wrap-around modulo 2^XLEN. Hold until mem_req_ready, then go to WAIT1.
  - WAIT1: on mem_rsp_valid, store beat1 and go to RESP.
  - RESP: wb_valid=1; all wb outputs are registered and held stable until wb_ready. On the handshake, return to IDLE.
- Data assembly: ({beat1,beat0} >> 8*off), truncated to size, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN.
- ld_ready = (state==IDLE) || (state==RESP && wb_ready). A new load is accepted in the same cycle as the wb handshake; there is no bubble.
- Latency with zero-wait cache: accept at cycle 0, mem_req_valid at cycle 1, wb_valid the cycle after the final mem_rsp_valid.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored. This covers late responses after reset.
- Reset mid-operation aborts the load; no wb_valid is ever produced for it.

Optional Feature:
- Macro LOAD_MISALIGN_SPLIT_EN.
- Defined: crossing loads are split into two beats as described above.
- Undefined: a crossing load issues no memory request and goes from IDLE directly to RESP with wb_fault=1 and wb_data=0. The REQ1 and WAIT1 states are not built.

Test Plan:
- XLEN=32, LB at 0x1003, word@0x1000=0x80FF1234 -> single request to 0x1000; wb_data=0xFFFFFF80; wb_fault=0; wb_valid the cycle after mem_rsp_valid.
- LHU at 0x1001, same word -> wb_data=0x0000FF12 (one beat, in-word unaligned access); LH at 0x1002 -> 0xFFFF80FF.
- With macro defined: LW at 0x1001, word@0x1000=0x44332211 and word@0x1004=0x88776655 -> requests to 0x1000 then 0x1004; wb_data=0x55443322. Without macro: no request; wb_fault=1; wb_data=0.
- Hold wb_ready=0 for 3 cycles with wb_valid high -> wb_data and wb_tag are stable. When wb_ready rises with ld_valid high, the next load is accepted in that same cycle.
- Assert rst_n=0 during WAIT0 -> outputs go to 0 immediately. A mem_rsp_valid pulse arriving after reset release produces no wb_valid, and the next load completes normally.
- XLEN=64: LWU at 0x2004, word=0x8000000100000000 -> wb_data=0x0000000080000001. LD at 0x2006 (macro on) -> two requests to 0x2000 and 0x2008; bytes are merged correctly.
